// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes and flit/index width helpers.
package noc_pkg;

  localparam int unsigned TYPEW_DEF = 2;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  // Port-index width; a single port still needs one bit to carry a pointer.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Flit width: type field sits above the payload.
  function automatic int unsigned flit_w(input int unsigned typew, input int unsigned dataw);
    return typew + dataw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NPORT = 5,
  parameter int unsigned PTRW  = idx_w(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PTRW-1:0]  ptr,
  input  logic             en,
  output logic [NPORT-1:0] gnt
);

  // Pick the requester with the smallest wrapped distance from ptr.
  always_comb begin
    int best_d;
    int best;
    int d;
    best_d = int'(NPORT);
    best   = 0;
    d      = 0;
    gnt    = '0;
    for (int j = 0; j < int'(NPORT); j++) begin
      d = (j - int'(ptr) + int'(NPORT)) % int'(NPORT);
      if (req[j] && (d < best_d)) begin
        best_d = d;
        best   = j;
      end
    end
    for (int j = 0; j < int'(NPORT); j++) begin
      gnt[j] = en && (best_d < int'(NPORT)) && (j == best);
    end
  end

endmodule

// File: rtl/pkt_mux_rr.sv
// Router output mux: wormhole-locked packet forwarding with round-robin or forced HEAD arbitration.
module pkt_mux_rr
  import noc_pkg::*;
#(
  parameter int unsigned NPORT = 5,
  parameter int unsigned DATAW = 64,
  parameter int unsigned TYPEW = TYPEW_DEF,
  parameter int unsigned VCHW  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NPORT*flit_w(TYPEW,DATAW)-1:0] idata,
  input  logic [NPORT-1:0]                    ivalid,
  input  logic [NPORT*VCHW-1:0]               ivch,
  output logic [NPORT-1:0]                    iready,
  input  logic                                sel_en,
  input  logic [NPORT-1:0]                    sel,
  output logic [flit_w(TYPEW,DATAW)-1:0]      odata,
  output logic                                ovalid,
  output logic [VCHW-1:0]                     ovch,
  input  logic                                oready,
  output logic [NPORT-1:0]                    lock_port,
  output logic                                perr
);

  localparam int unsigned FW   = flit_w(TYPEW, DATAW);
  localparam int unsigned PTRW = idx_w(NPORT);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [NPORT-1:0] lock_d;
  logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             perr_d;

  logic [FW-1:0]    flit [NPORT];
  logic [VCHW-1:0]  vch  [NPORT];
  logic [NPORT-1:0] cand, rr_gnt, sel_low, grant, route;
  logic [PTRW-1:0]  gnt_idx;
  logic [FW-1:0]    mux_data;
  logic [VCHW-1:0]  mux_vch;
  logic [TYPEW-1:0] mux_type;
  logic             mux_valid, out_free, xfer;

  for (genvar p = 0; p < int'(NPORT); p++) begin : g_slice
    assign flit[p] = idata[p*FW +: FW];
    assign vch[p]  = ivch[p*VCHW +: VCHW];
    assign cand[p] = ivalid[p] && (flit[p][FW-1 -: TYPEW] == TYPEW'(TYPE_HEAD));
  end

  rr_arbiter #(.NPORT(NPORT), .PTRW(PTRW)) u_arb (
    .req (cand),
    .ptr (rr_ptr_q),
    .en  (!sel_en),
    .gnt (rr_gnt)
  );

  // Forced mode honours only the lowest set bit of sel, and only if it holds a HEAD.
  always_comb begin
    sel_low = sel & (~sel + NPORT'(1));
    grant   = sel_en ? (sel_low & cand) : rr_gnt;
    route   = (state_q == ST_IDLE) ? grant : lock_port;
  end

  always_comb begin
    mux_data = '0;
    mux_vch  = '0;
    gnt_idx  = '0;
    for (int j = 0; j < int'(NPORT); j++) begin
      if (route[j]) begin
        mux_data = mux_data | flit[j];
        mux_vch  = mux_vch | vch[j];
      end
      if (grant[j]) gnt_idx = PTRW'(j);
    end
    mux_type  = mux_data[FW-1 -: TYPEW];
    mux_valid = |(route & ivalid);
    out_free  = !ovalid || oready;
    xfer      = mux_valid && out_free;
    iready    = rst ? '0 : (route & {NPORT{out_free}});
  end

  // Next-state logic: lock on HEAD grant, release on TAIL, flag stray HEAD/NONE from owner.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_port;
    rr_ptr_d = rr_ptr_q;
    perr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_LOCKED;
          lock_d  = grant;
          if (!sel_en) begin
            rr_ptr_d = (gnt_idx == PTRW'(NPORT - 1)) ? '0 : gnt_idx + PTRW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          if (mux_type == TYPEW'(TYPE_TAIL)) begin
            state_d = ST_IDLE;
            lock_d  = '0;
          end else if (mux_type != TYPEW'(TYPE_DATA)) begin
            perr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        lock_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_port <= '0;
      rr_ptr_q  <= '0;
      perr      <= 1'b0;
      ovalid    <= 1'b0;
      odata     <= '0;
      ovch      <= '0;
    end else begin
      state_q   <= state_d;
      lock_port <= lock_d;
      rr_ptr_q  <= rr_ptr_d;
      perr      <= perr_d;
      if (xfer) begin
        ovalid <= 1'b1;
        odata  <= mux_data;
        ovch   <= mux_vch;
      end else if (oready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_mux_rr.sv
// Directed bench for pkt_mux_rr: per-port flit queues feed the DUT, a scoreboard holds the expected output stream.
module tb_pkt_mux_rr;
  import noc_pkg::*;

  localparam int unsigned NPORT = 5;
  localparam int unsigned DATAW = 64;
  localparam int unsigned TYPEW = 2;
  localparam int unsigned VCHW  = 1;
  localparam int unsigned FW    = TYPEW + DATAW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NPORT*FW-1:0]   idata;
  logic [NPORT-1:0]      ivalid;
  logic [NPORT*VCHW-1:0] ivch;
  logic [NPORT-1:0]      iready;
  logic                  sel_en;
  logic [NPORT-1:0]      sel;
  logic [FW-1:0]         odata;
  logic                  ovalid;
  logic [VCHW-1:0]       ovch;
  logic                  oready;
  logic [NPORT-1:0]      lock_port;
  logic                  perr;

  always #5 clk = ~clk;

  pkt_mux_rr #(.NPORT(NPORT), .DATAW(DATAW), .TYPEW(TYPEW), .VCHW(VCHW)) dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
    .sel_en(sel_en), .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .oready(oready), .lock_port(lock_port), .perr(perr)
  );

  typedef struct packed {
    logic [FW-1:0]    flit;
    logic [VCHW-1:0]  vch;
    logic             perr;
    logic [NPORT-1:0] lock;
  } exp_t;

  logic [FW-1:0] pq [NPORT][$];
  exp_t          exp_q[$];
  int errors = 0;
  int checks = 0;
  int seq    = 0;
  int ncyc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Queue one flit on port p and append its expected appearance on the output.
  task automatic push_flit(input int p, input logic [1:0] typ, input logic perr_f);
    exp_t          e;
    logic [FW-1:0] f;
    f = {typ, DATAW'(p * 4096 + seq)};
    seq++;
    pq[p].push_back(f);
    e.flit = f;
    e.vch  = VCHW'(p % 2);
    e.perr = perr_f;
    e.lock = (typ == TYPE_TAIL) ? '0 : (NPORT'(1) << p);
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input int p, input int ndata);
    push_flit(p, TYPE_HEAD, 1'b0);
    for (int i = 0; i < ndata; i++) push_flit(p, TYPE_DATA, 1'b0);
    push_flit(p, TYPE_TAIL, 1'b0);
  endtask

  // Drive queued flits until the scoreboard drains; oready drops for stall_len cycles from stall_at.
  task automatic run(input string name, input int stall_at, input int stall_len,
                     input int sw_at, input logic [NPORT-1:0] sel_after, output int cycles);
    int               cyc;
    logic             held;
    logic [FW-1:0]    hdata;
    logic [NPORT-1:0] x;
    exp_t             e;
    cyc  = 0;
    held = 1'b0;
    hdata = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      oready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (cyc == sw_at) sel = sel_after;
      for (int p = 0; p < int'(NPORT); p++) begin
        if (pq[p].size() > 0) begin
          ivalid[p] = 1'b1;
          idata[p*FW +: FW] = pq[p][0];
        end else begin
          ivalid[p] = 1'b0;
        end
        ivch[p*VCHW +: VCHW] = VCHW'(p % 2);
      end
      #1;
      if (held) check({name, "_hold"}, odata, hdata);
      held = 1'b0;
      if (ovalid && oready) begin
        e = exp_q.pop_front();
        check({name, "_data"}, odata, e.flit);
        check({name, "_vch"}, ovch, e.vch);
        check({name, "_perr"}, perr, e.perr);
        check({name, "_lock"}, lock_port, e.lock);
      end else if (ovalid) begin
        check({name, "_stall_iready"}, iready, '0);
        held  = 1'b1;
        hdata = odata;
      end
      x = iready & ivalid;
      for (int p = 0; p < int'(NPORT); p++) if (x[p]) void'(pq[p].pop_front());
      @(posedge clk);
      #1;
      if (x != '0) check({name, "_latency"}, ovalid, 1'b1);
      cyc++;
    end
    cycles = cyc;
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_idle_ovalid"}, ovalid, 1'b0);
    check({name, "_idle_lock"}, lock_port, '0);
    ivalid = '0;
    oready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idata = '0; ivalid = '0; ivch = '0; sel_en = 1'b0; sel = '0; oready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_ovalid", ovalid, 1'b0);
    check("rst_odata", odata, '0);
    check("rst_ovch", ovch, '0);
    check("rst_iready", iready, '0);
    check("rst_lock", lock_port, '0);
    check("rst_perr", perr, 1'b0);

    // Single 22-flit packet on port 1.
    push_pkt(1, 20);
    run("single", -1, 0, -1, '0, ncyc);
    check("single_cycles", ncyc, 23);

    // Three competing HEADs from rr_ptr=0, then a 0-vs-1 race shows rr_ptr wrapped to 0.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    push_pkt(0, 1);
    push_pkt(2, 1);
    push_pkt(4, 1);
    run("rr3", -1, 0, -1, '0, ncyc);
    push_pkt(0, 0);
    push_pkt(1, 0);
    run("rr_wrap", -1, 0, -1, '0, ncyc);

    // Downstream stall mid-packet on port 3.
    push_pkt(3, 4);
    run("stall", 2, 4, -1, '0, ncyc);

    // Forced selection: port 3 wins, sel change mid-packet waits for the TAIL.
    sel_en = 1'b1;
    sel    = 5'b01000;
    push_pkt(3, 1);
    push_pkt(1, 1);
    run("forced", -1, 0, 1, 5'b00010, ncyc);
    sel_en = 1'b0;
    sel    = '0;

    // Owner presents HEAD and NONE while locked.
    push_flit(2, TYPE_HEAD, 1'b0);
    push_flit(2, TYPE_HEAD, 1'b1);
    push_flit(2, TYPE_NONE, 1'b1);
    push_flit(2, TYPE_DATA, 1'b0);
    push_flit(2, TYPE_TAIL, 1'b0);
    run("perr", -1, 0, -1, '0, ncyc);

    // Reset in the middle of a packet on port 0.
    ivalid = 5'b00001;
    idata[0 +: FW] = {TYPE_HEAD, DATAW'(64'h11)};
    @(posedge clk); #1;
    idata[0 +: FW] = {TYPE_DATA, DATAW'(64'h12)};
    @(posedge clk); #1;
    check("pre_rst_lock", lock_port, 5'b00001);
    check("pre_rst_data", odata, {TYPE_DATA, DATAW'(64'h12)});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ivalid = '0;
    #1;
    check("midrst_ovalid", ovalid, 1'b0);
    check("midrst_lock", lock_port, '0);
    check("midrst_iready", iready, '0);
    check("midrst_perr", perr, 1'b0);
    push_pkt(4, 2);
    run("after_rst", -1, 0, -1, '0, ncyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
